// File: rtl/sram_interface.sv
// rtl/sram_interface.sv - single-access command responder driving an asynchronous 16-bit SRAM pair
module sram_interface #(
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic        CLK_48MHZ,
    input  logic        RESET,
    input  logic [1:0]  CMD_IN,
    input  logic [15:0] DATA_IN,
    input  logic [17:0] ADDRESS_IN,
    input  logic        CHIP_SELECT_IN,
    output logic        SRAM_STATUS,
    output logic [15:0] READ_DATA,
    output logic        READ_VALID,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    input  logic [15:0] SRAM_DQ_IN,
    output logic [1:0]  SRAM_CE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_UB_N
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    // Phase counters count 0..N-1, so each phase lasts exactly N clocks.
    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] phase_cnt;
    logic       armed;
    logic       is_write;
    logic [3:0] phase_last;
    logic       accept;
    logic       phase_done;
    logic       setup_done;
    logic       pulse_done;
    logic       hold_done;

    // Accept decode and end-of-phase detection.
    always_comb begin
        phase_last = 4'd0;
        case (state)
            ST_SETUP: phase_last = SETUP_LAST;
            ST_PULSE: phase_last = PULSE_LAST;
            ST_HOLD:  phase_last = HOLD_LAST;
            default:  phase_last = 4'd0;
        endcase
        accept     = (state == ST_IDLE) && armed &&
                     ((CMD_IN == CMD_WRITE) || (CMD_IN == CMD_READ));
        phase_done = (state != ST_IDLE) && (phase_cnt == phase_last);
        setup_done = phase_done && (state == ST_SETUP);
        pulse_done = phase_done && (state == ST_PULSE);
        hold_done  = phase_done && (state == ST_HOLD);
    end

    // Phase sequencing and the arm flag that forces CMD_IN back to idle between accesses.
    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            phase_cnt <= 4'd0;
            armed     <= 1'b0;
            is_write  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    phase_cnt <= 4'd0;
                    if (accept) begin
                        state    <= ST_SETUP;
                        armed    <= 1'b0;
                        is_write <= (CMD_IN == CMD_WRITE);
                    end else if (CMD_IN == CMD_IDLE) begin
                        armed <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (phase_done) begin
                        state     <= ST_PULSE;
                        phase_cnt <= 4'd0;
                    end else begin
                        phase_cnt <= phase_cnt + 4'd1;
                    end
                end
                ST_PULSE: begin
                    if (phase_done) begin
                        state     <= ST_HOLD;
                        phase_cnt <= 4'd0;
                    end else begin
                        phase_cnt <= phase_cnt + 4'd1;
                    end
                end
                default: begin
                    if (phase_done) begin
                        state     <= ST_IDLE;
                        phase_cnt <= 4'd0;
                    end else begin
                        phase_cnt <= phase_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    // Registered SRAM pins: chip/byte enables, address and write data span the whole access.
    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            SRAM_STATUS <= 1'b0;
            SRAM_ADDR   <= 18'd0;
            SRAM_DQ_OUT <= 16'd0;
            SRAM_DQ_OE  <= 1'b0;
            SRAM_CE_N   <= 2'b11;
            SRAM_LB_N   <= 1'b1;
            SRAM_UB_N   <= 1'b1;
        end else if (accept) begin
            SRAM_STATUS <= 1'b1;
            SRAM_ADDR   <= ADDRESS_IN;
            SRAM_CE_N   <= CHIP_SELECT_IN ? 2'b01 : 2'b10;
            SRAM_LB_N   <= 1'b0;
            SRAM_UB_N   <= 1'b0;
            SRAM_DQ_OE  <= (CMD_IN == CMD_WRITE);
            if (CMD_IN == CMD_WRITE) begin
                SRAM_DQ_OUT <= DATA_IN;
            end
        end else if (hold_done) begin
            SRAM_STATUS <= 1'b0;
            SRAM_DQ_OE  <= 1'b0;
            SRAM_CE_N   <= 2'b11;
            SRAM_LB_N   <= 1'b1;
            SRAM_UB_N   <= 1'b1;
        end
    end

    // Strobes: WE_N or OE_N low for the PULSE phase only.
    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
        end else if (setup_done) begin
            SRAM_WE_N <= !is_write;
            SRAM_OE_N <= is_write;
        end else if (pulse_done) begin
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
        end
    end

    // Read capture on the edge that ends the strobe, with a one-cycle valid pulse.
    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            READ_DATA  <= 16'd0;
            READ_VALID <= 1'b0;
        end else begin
            READ_VALID <= 1'b0;
            if (pulse_done && !is_write) begin
                READ_DATA  <= SRAM_DQ_IN;
                READ_VALID <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_interface.sv
// tb/tb_sram_interface.sv - randomized and directed bench for sram_interface against a transaction model
module tb_sram_interface;

    localparam int S = 2;
    localparam int P = 4;
    localparam int H = 2;
    localparam int T = S + P + H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cmd = 2'd0;
    logic [15:0] data_in = 16'd0;
    logic [17:0] addr_in = 18'd0;
    logic        cs = 1'b0;
    logic        status;
    logic [15:0] read_data;
    logic        read_valid;
    logic [17:0] sram_addr;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [15:0] dq_in = 16'd0;
    logic [1:0]  ce_n;
    logic        we_n;
    logic        oe_n;
    logic        lb_n;
    logic        ub_n;

    sram_interface #(
        .SETUP_CYCLES(S),
        .PULSE_CYCLES(P),
        .HOLD_CYCLES(H)
    ) dut (
        .CLK_48MHZ(clk),
        .RESET(rst_n),
        .CMD_IN(cmd),
        .DATA_IN(data_in),
        .ADDRESS_IN(addr_in),
        .CHIP_SELECT_IN(cs),
        .SRAM_STATUS(status),
        .READ_DATA(read_data),
        .READ_VALID(read_valid),
        .SRAM_ADDR(sram_addr),
        .SRAM_DQ_OUT(dq_out),
        .SRAM_DQ_OE(dq_oe),
        .SRAM_DQ_IN(dq_in),
        .SRAM_CE_N(ce_n),
        .SRAM_WE_N(we_n),
        .SRAM_OE_N(oe_n),
        .SRAM_LB_N(lb_n),
        .SRAM_UB_N(ub_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // Transaction-level model: an access is "k cycles old" and everything follows from k.
    logic        m_active;
    int          m_k;
    logic        m_armed;
    logic        m_write;
    logic [17:0] m_addr;
    logic [15:0] m_data;
    logic        m_chip;
    logic [15:0] m_rd;
    logic        m_rv;

    logic [15:0] ref_mem  [logic [18:0]];
    logic [15:0] sram_mem [logic [18:0]];

    int cnt_busy, cnt_we, cnt_oe, cnt_rv, rv_at, cnt_wr_match;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_k      = 0;
        m_armed  = 1'b0;
        m_write  = 1'b0;
        m_addr   = 18'd0;
        m_data   = 16'd0;
        m_chip   = 1'b0;
        m_rd     = 16'd0;
        m_rv     = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] c);
        logic [18:0] key;
        m_rv = 1'b0;
        if (!m_active) begin
            if (m_armed && (c == 2'd1 || c == 2'd2)) begin
                m_active = 1'b1;
                m_k      = 0;
                m_armed  = 1'b0;
                m_write  = (c == 2'd1);
                m_addr   = addr_in;
                m_chip   = cs;
                if (c == 2'd1) begin
                    m_data = data_in;
                    ref_mem[{cs, addr_in}] = data_in;
                end
            end else if (c == 2'd0) begin
                m_armed = 1'b1;
            end
        end else begin
            m_k++;
            if (m_k == S + P && !m_write) begin
                key  = {m_chip, m_addr};
                m_rd = ref_mem.exists(key) ? ref_mem[key] : 16'd0;
                m_rv = 1'b1;
            end
            if (m_k == T) m_active = 1'b0;
        end
    endtask

    task automatic check_pins();
        logic strobe;
        strobe = m_active && (m_k >= S) && (m_k < S + P);
        check_eq("status", status, m_active);
        check_eq("ce_n", ce_n, m_active ? (m_chip ? 2'b01 : 2'b10) : 2'b11);
        check_eq("lb_n", lb_n, !m_active);
        check_eq("ub_n", ub_n, !m_active);
        check_eq("we_n", we_n, !(strobe && m_write));
        check_eq("oe_n", oe_n, !(strobe && !m_write));
        check_eq("dq_oe", dq_oe, m_active && m_write);
        check_eq("sram_addr", sram_addr, m_addr);
        if (m_active && m_write) check_eq("dq_out", dq_out, m_data);
        check_eq("read_valid", read_valid, m_rv);
        check_eq("read_data", read_data, m_rd);
        cnt_busy += int'(status);
        cnt_we   += int'(!we_n);
        cnt_oe   += int'(!oe_n);
        cnt_rv   += int'(read_valid);
        if (read_valid) rv_at = cyc;
        if (dq_oe && ce_n == 2'b01 && dq_out == 16'h00A0 && sram_addr == 18'd25) cnt_wr_match++;
    endtask

    // Bench-side SRAM: stores on WE_N low, returns stored data while OE_N low, noise otherwise.
    task automatic sram_update();
        logic [18:0] key;
        key = {ce_n == 2'b01, sram_addr};
        if (!we_n && dq_oe && ce_n != 2'b11) sram_mem[key] = dq_out;
        if (!oe_n && ce_n != 2'b11)
            dq_in = sram_mem.exists(key) ? sram_mem[key] : 16'd0;
        else
            dq_in = 16'($urandom);
    endtask

    task automatic cycle(input logic [1:0] c);
        cmd = c;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(c);
        @(negedge clk);
        cyc++;
        check_pins();
        sram_update();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(2'd0);
    endtask

    task automatic clear_counts();
        cnt_busy = 0; cnt_we = 0; cnt_oe = 0; cnt_rv = 0; rv_at = -1; cnt_wr_match = 0;
    endtask

    initial begin
        int acc_at;
        logic [1:0] rc;
        int n;
        model_reset();
        clear_counts();
        @(negedge clk);
        cycle(2'd1);
        cycle(2'd1);
        check_eq("rst_dq_out", dq_out, 16'd0);
        check_eq("rst_addr", sram_addr, 18'd0);
        rst_n = 1'b1;
        idle(2);

        // Write chip 1, address 25, data 0x00A0.
        clear_counts();
        cs = 1'b1; addr_in = 18'd25; data_in = 16'h00A0;
        cycle(2'd1);
        idle(12);
        check_eq("wr_we_low_cycles", cnt_we, 4);
        check_eq("wr_busy_cycles", cnt_busy, 8);
        check_eq("wr_pins_cycles", cnt_wr_match, 8);
        check_eq("wr_no_valid", cnt_rv, 0);

        // Read chip 0, address 6 returning 0xBEEF.
        sram_mem[{1'b0, 18'd6}] = 16'hBEEF;
        ref_mem[{1'b0, 18'd6}]  = 16'hBEEF;
        clear_counts();
        cs = 1'b0; addr_in = 18'd6; data_in = 16'h1234;
        cycle(2'd2);
        acc_at = cyc;
        idle(12);
        check_eq("rd_oe_low_cycles", cnt_oe, 4);
        check_eq("rd_valid_count", cnt_rv, 1);
        check_eq("rd_valid_latency", rv_at - acc_at, 6);
        check_eq("rd_data", read_data, 16'hBEEF);

        // Held command produces one access; one idle edge re-arms.
        clear_counts();
        cs = 1'b1; addr_in = 18'd7; data_in = 16'h5A5A;
        for (int i = 0; i < 30; i++) cycle(2'd1);
        check_eq("held_busy_cycles", cnt_busy, 8);
        cycle(2'd0);
        cycle(2'd2);
        check_eq("rearm_accept", status, 1'b1);
        idle(12);
        check_eq("rearm_read_data", read_data, 16'h5A5A);

        // Command changed to read during a write's strobe.
        clear_counts();
        cs = 1'b0; addr_in = 18'd9; data_in = 16'hC3C3;
        cycle(2'd1);
        cycle(2'd0); cycle(2'd0); cycle(2'd0);
        cycle(2'd2); cycle(2'd2); cycle(2'd2);
        idle(8);
        check_eq("chg_we_cycles", cnt_we, 4);
        check_eq("chg_oe_cycles", cnt_oe, 0);
        check_eq("chg_busy_cycles", cnt_busy, 8);

        // Reserved command neither accesses nor arms, nor disarms.
        clear_counts();
        for (int i = 0; i < 5; i++) cycle(2'd3);
        check_eq("rsv_busy_cycles", cnt_busy, 0);
        cycle(2'd3);
        cycle(2'd1);
        check_eq("rsv_then_write", status, 1'b1);
        idle(12);

        // Reset during a read strobe.
        clear_counts();
        cs = 1'b1; addr_in = 18'd3;
        cycle(2'd2);
        cycle(2'd2); cycle(2'd2); cycle(2'd2);
        check_eq("pre_rst_oe_n", oe_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_ce_n", ce_n, 2'b11);
        check_eq("async_oe_n", oe_n, 1'b1);
        check_eq("async_status", status, 1'b0);
        check_eq("async_read_valid", read_valid, 1'b0);
        model_reset();
        cycle(2'd2);
        rst_n = 1'b1;
        clear_counts();
        for (int i = 0; i < 6; i++) cycle(2'd2);
        check_eq("post_rst_ignored", cnt_busy, 0);
        cycle(2'd0);
        cycle(2'd2);
        check_eq("post_rst_accept", status, 1'b1);
        idle(12);

        // Randomized bursts of held commands.
        for (int b = 0; b < 200; b++) begin
            n = $urandom_range(0, 9);
            rc = (n < 4) ? 2'd0 : (n < 6) ? 2'd1 : (n < 9) ? 2'd2 : 2'd3;
            cs = 1'($urandom);
            addr_in = ($urandom_range(0, 7) == 0) ? 18'($urandom) : 18'($urandom_range(0, 15));
            data_in = 16'($urandom);
            n = $urandom_range(1, 12);
            for (int j = 0; j < n; j++) cycle(rc);
        end
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
